// File: rtl/ysyx_22050612_pkg.sv
// Shared definitions for the ysyx_22050612 core front end: fetch FSM encoding,
// control-register bundle and well-known instruction encodings.
package ysyx_22050612_pkg;

    localparam int          XLEN_DEF     = 64;
    localparam logic [63:0] RESET_PC_DEF = 64'h0000_0000_8000_0000;
    localparam logic [31:0] NOP_INST     = 32'h0000_0013;
    localparam logic [31:0] EBREAK_INST  = 32'h0010_0073;

    typedef enum logic [2:0] {
        IFU_IDLE = 3'd0,
        IFU_REQ  = 3'd1,
        IFU_WAIT = 3'd2,
        IFU_OUT  = 3'd3,
        IFU_HALT = 3'd4
    } ifu_state_e;

    // Fetch control state gathered in one struct so it is visible as a single
    // hierarchical signal; drop marks an outstanding response to be discarded.
    typedef struct packed {
        ifu_state_e state;
        logic       drop;
        logic       halt_seen;
    } ifu_ctl_t;

    function automatic logic is_ebreak(input logic [31:0] word);
        return word == EBREAK_INST;
    endfunction

endpackage

// File: rtl/ysyx_22050612_ifu.sv
// Instruction fetch unit: one outstanding 32-bit fetch at a time, redirect
// squashes in-flight work, halt or access fault stop fetching until reset.
module ysyx_22050612_ifu
    import ysyx_22050612_pkg::*;
#(
    parameter int               XLEN     = XLEN_DEF,
    parameter logic [XLEN-1:0]  RESET_PC = XLEN'(RESET_PC_DEF)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            halt,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            imem_rsp_err,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] inst_pc,
    output logic            inst_fault
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; valid never waits on ready, and payload holds while valid is high.

    ifu_ctl_t        ctl_q;
    logic [XLEN-1:0] pc_q;
    logic [31:0]     inst_q;
    logic [XLEN-1:0] inst_pc_q;
    logic            fault_q;

    logic            halt_any;
    logic            req_fire;
    logic [XLEN-1:0] redirect_tgt;
    logic [XLEN-1:0] pc_next_seq;

    assign halt_any     = halt | ctl_q.halt_seen;
    assign redirect_tgt = {redirect_pc[XLEN-1:2], 2'b00};
    assign pc_next_seq  = pc_q + XLEN'(4);

    // halt is the only input allowed to reach an output without a register.
    assign imem_req_valid = (ctl_q.state == IFU_REQ) && !halt_any;
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign inst_valid = (ctl_q.state == IFU_OUT);
    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;
    assign inst_fault = fault_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctl_q.state     <= IFU_IDLE;
            ctl_q.drop      <= 1'b0;
            ctl_q.halt_seen <= 1'b0;
            pc_q            <= RESET_PC;
            inst_q          <= 32'h0;
            inst_pc_q       <= '0;
            fault_q         <= 1'b0;
        end else begin
            if (halt && ctl_q.state != IFU_HALT) begin
                ctl_q.halt_seen <= 1'b1;
            end

            case (ctl_q.state)
                IFU_IDLE: begin
                    ctl_q.state <= IFU_REQ;
                end

                IFU_REQ: begin
                    if (redirect_valid) begin
                        // A request already on the bus carries the old pc; its response is dropped.
                        pc_q <= redirect_tgt;
                        if (req_fire) begin
                            ctl_q.state <= IFU_WAIT;
                            ctl_q.drop  <= 1'b1;
                        end
                    end else if (halt_any) begin
                        ctl_q.state <= IFU_HALT;
                    end else if (req_fire) begin
                        ctl_q.state <= IFU_WAIT;
                    end
                end

                IFU_WAIT: begin
                    if (redirect_valid) begin
                        pc_q <= redirect_tgt;
                        if (imem_rsp_valid) begin
                            ctl_q.state <= IFU_REQ;
                            ctl_q.drop  <= 1'b0;
                        end else begin
                            ctl_q.drop  <= 1'b1;
                        end
                    end else if (imem_rsp_valid) begin
                        if (ctl_q.drop) begin
                            ctl_q.drop  <= 1'b0;
                            ctl_q.state <= IFU_REQ;
                        end else begin
                            inst_q      <= imem_rsp_err ? NOP_INST : imem_rsp_data;
                            fault_q     <= imem_rsp_err;
                            inst_pc_q   <= pc_q;
                            ctl_q.state <= IFU_OUT;
                        end
                    end
                end

                IFU_OUT: begin
                    if (redirect_valid) begin
                        // Decode ignores a handshake that coincides with a redirect.
                        pc_q        <= redirect_tgt;
                        ctl_q.state <= IFU_REQ;
                    end else if (inst_ready) begin
                        pc_q <= pc_next_seq;
                        if (fault_q || halt_any) begin
                            ctl_q.state <= IFU_HALT;
                        end else begin
                            ctl_q.state <= IFU_REQ;
                        end
                    end
                end

                IFU_HALT: begin
                    ctl_q.state <= IFU_HALT;
                end

                default: begin
                    ctl_q.state <= IFU_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22050612_ifu.sv
// Directed bench for the fetch unit: a tick-driven instruction memory model
// with programmable response delay, error injection and request stalls.
module tb_ysyx_22050612_ifu;
    import ysyx_22050612_pkg::*;

    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            redirect_valid = 1'b0;
    logic [XLEN-1:0] redirect_pc = '0;
    logic            halt = 1'b0;
    logic            imem_req_valid;
    logic            imem_req_ready = 1'b1;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid = 1'b0;
    logic [31:0]     imem_rsp_data = 32'h0;
    logic            imem_rsp_err = 1'b0;
    logic            inst_valid;
    logic            inst_ready = 1'b0;
    logic [31:0]     inst;
    logic [XLEN-1:0] inst_pc;
    logic            inst_fault;

    int checks = 0;
    int failures = 0;
    int req_count = 0;

    logic            pend = 1'b0;
    logic [XLEN-1:0] pend_addr = '0;
    int              pend_cnt = 0;
    int              rsp_delay = 1;
    logic            err_mode = 1'b0;

    logic [31:0] exp_q[$];

    ysyx_22050612_ifu #(
        .XLEN     (64),
        .RESET_PC (64'h0000_0000_8000_0000)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .imem_rsp_err   (imem_rsp_err),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_fault     (inst_fault)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- memory model ----------------
    function automatic logic [31:0] mem_word(input logic [63:0] a);
        if (a == 64'h8000_0000) return 32'h0000_0013;
        if (a == 64'h8000_0004) return 32'h0010_0093;
        return a[31:0] ^ 32'hA5A5_0000;
    endfunction

    // One clock: sample the request at mid-cycle, then update memory inputs after the edge.
    task automatic tick();
        logic            fired;
        logic [XLEN-1:0] a;
        @(negedge clk);
        fired = imem_req_valid && imem_req_ready;
        a     = imem_req_addr;
        @(posedge clk);
        #1;
        imem_rsp_valid = 1'b0;
        imem_rsp_err   = 1'b0;
        imem_rsp_data  = 32'h0;
        if (fired) begin
            req_count++;
            pend      = 1'b1;
            pend_addr = a;
            pend_cnt  = rsp_delay;
        end
        if (pend) begin
            if (pend_cnt <= 1) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_word(pend_addr);
                imem_rsp_err   = err_mode;
                pend           = 1'b0;
            end else begin
                pend_cnt--;
            end
        end
    endtask

    task automatic assert_reset();
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        halt           = 1'b0;
        inst_ready     = 1'b0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_err   = 1'b0;
        imem_rsp_data  = 32'h0;
        err_mode       = 1'b0;
        pend           = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic wait_inst(input int max, output int n);
        n = 0;
        for (int i = 1; i <= max; i++) begin
            tick();
            if (inst_valid) begin
                n = i;
                break;
            end
        end
        checks++;
        if (n == 0) begin
            failures++;
            $display("FAIL wait_inst: no inst_valid within %0d cycles", max);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        assert_reset();
        checks++;
        if ({imem_req_valid, inst_valid, inst_fault} !== 3'b000) begin
            failures++;
            $display("FAIL reset_valids: got %b exp 000", {imem_req_valid, inst_valid, inst_fault});
        end
        checks++;
        if (imem_req_addr !== 64'h8000_0000) begin
            failures++;
            $display("FAIL reset_addr: got %h exp 80000000", imem_req_addr);
        end
        checks++;
        if (inst !== 32'h0 || inst_pc !== 64'h0) begin
            failures++;
            $display("FAIL reset_inst: got inst=%h pc=%h exp 0/0", inst, inst_pc);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (imem_req_valid !== 1'b0) begin
            failures++;
            $display("FAIL idle_no_req: got %b exp 0", imem_req_valid);
        end
        tick();
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0000) begin
            failures++;
            $display("FAIL first_req: got v=%b a=%h exp 1/80000000", imem_req_valid, imem_req_addr);
        end
    endtask

    task automatic test_zero_wait();
        int r0;
        logic [31:0] e;
        imem_req_ready = 1'b1;
        inst_ready     = 1'b1;
        rsp_delay      = 1;
        exp_q.push_back(32'h0000_0013);
        exp_q.push_back(32'h0010_0093);
        r0 = req_count;
        tick();
        checks++;
        if (inst_valid !== 1'b0) begin
            failures++;
            $display("FAIL zw_wait: inst_valid got %b exp 0", inst_valid);
        end
        tick();
        e = exp_q.pop_front();
        checks++;
        if (inst_valid !== 1'b1 || inst !== e || inst_pc !== 64'h8000_0000) begin
            failures++;
            $display("FAIL zw_inst0: got v=%b i=%h pc=%h exp 1/%h/80000000", inst_valid, inst, inst_pc, e);
        end
        tick();
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0004) begin
            failures++;
            $display("FAIL zw_req1: got v=%b a=%h exp 1/80000004", imem_req_valid, imem_req_addr);
        end
        tick();
        tick();
        e = exp_q.pop_front();
        checks++;
        if (inst_valid !== 1'b1 || inst !== e || inst_pc !== 64'h8000_0004) begin
            failures++;
            $display("FAIL zw_inst1: got v=%b i=%h pc=%h exp 1/%h/80000004", inst_valid, inst, inst_pc, e);
        end
        checks++;
        if (req_count - r0 !== 2) begin
            failures++;
            $display("FAIL zw_req_count: got %0d exp 2", req_count - r0);
        end
    endtask

    task automatic test_stall();
        int r0;
        int n;
        imem_req_ready = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0008) begin
                failures++;
                $display("FAIL stall_req[%0d]: got v=%b a=%h exp 1/80000008", i, imem_req_valid, imem_req_addr);
            end
            tick();
        end
        imem_req_ready = 1'b1;
        inst_ready     = 1'b0;
        rsp_delay      = 4;
        r0 = req_count;
        tick();
        wait_inst(10, n);
        checks++;
        if (n !== 4 || inst !== 32'h25A5_0008 || inst_pc !== 64'h8000_0008) begin
            failures++;
            $display("FAIL stall_inst: got n=%0d i=%h pc=%h exp 4/25a50008/80000008", n, inst, inst_pc);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (inst_valid !== 1'b1 || inst !== 32'h25A5_0008 || inst_pc !== 64'h8000_0008) begin
                failures++;
                $display("FAIL stall_hold[%0d]: got v=%b i=%h pc=%h", i, inst_valid, inst, inst_pc);
            end
        end
        checks++;
        if (req_count - r0 !== 1) begin
            failures++;
            $display("FAIL stall_req_count: got %0d exp 1", req_count - r0);
        end
        inst_ready = 1'b1;
        tick();
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_000C) begin
            failures++;
            $display("FAIL stall_next: got v=%b a=%h exp 1/8000000c", imem_req_valid, imem_req_addr);
        end
    endtask

    task automatic test_redirect_wait();
        int n;
        rsp_delay = 2;
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_1002;
        tick();
        redirect_valid = 1'b0;
        checks++;
        if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0 || imem_req_addr !== 64'h8000_1000) begin
            failures++;
            $display("FAIL rw_wait: got rv=%b iv=%b a=%h exp 0/0/80001000", imem_req_valid, inst_valid, imem_req_addr);
        end
        tick();
        checks++;
        if (imem_req_valid !== 1'b1 || inst_valid !== 1'b0 || imem_req_addr !== 64'h8000_1000) begin
            failures++;
            $display("FAIL rw_refetch: got rv=%b iv=%b a=%h exp 1/0/80001000", imem_req_valid, inst_valid, imem_req_addr);
        end
        wait_inst(8, n);
        checks++;
        if (n !== 3 || inst !== 32'h25A5_1000 || inst_pc !== 64'h8000_1000) begin
            failures++;
            $display("FAIL rw_inst: got n=%0d i=%h pc=%h exp 3/25a51000/80001000", n, inst, inst_pc);
        end
    endtask

    task automatic test_back_to_back_redirect();
        int r0;
        int n;
        inst_ready = 1'b1;
        tick();
        rsp_delay      = 3;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_2000;
        r0 = req_count;
        tick();
        checks++;
        if (req_count - r0 !== 1 || imem_req_valid !== 1'b0 || imem_req_addr !== 64'h8000_2000) begin
            failures++;
            $display("FAIL b2b_first: got reqs=%0d rv=%b a=%h exp 1/0/80002000", req_count - r0, imem_req_valid, imem_req_addr);
        end
        redirect_pc = 64'h8000_3000;
        tick();
        redirect_valid = 1'b0;
        checks++;
        if (imem_req_addr !== 64'h8000_3000 || inst_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_second: got a=%h iv=%b exp 80003000/0", imem_req_addr, inst_valid);
        end
        wait_inst(12, n);
        checks++;
        if (n !== 6 || inst !== 32'h25A5_3000 || inst_pc !== 64'h8000_3000) begin
            failures++;
            $display("FAIL b2b_inst: got n=%0d i=%h pc=%h exp 6/25a53000/80003000", n, inst, inst_pc);
        end
        checks++;
        if (req_count - r0 !== 2) begin
            failures++;
            $display("FAIL b2b_req_count: got %0d exp 2", req_count - r0);
        end
    endtask

    task automatic test_redirect_out();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_4000;
        inst_ready     = 1'b1;
        tick();
        redirect_valid = 1'b0;
        checks++;
        if (imem_req_valid !== 1'b1 || inst_valid !== 1'b0 || imem_req_addr !== 64'h8000_4000) begin
            failures++;
            $display("FAIL ro_req: got rv=%b iv=%b a=%h exp 1/0/80004000", imem_req_valid, inst_valid, imem_req_addr);
        end
    endtask

    task automatic test_error();
        int r0;
        int n;
        rsp_delay  = 1;
        err_mode   = 1'b1;
        inst_ready = 1'b0;
        wait_inst(6, n);
        err_mode = 1'b0;
        checks++;
        if (inst !== 32'h0000_0013 || inst_fault !== 1'b1 || inst_pc !== 64'h8000_4000) begin
            failures++;
            $display("FAIL err_inst: got i=%h f=%b pc=%h exp 00000013/1/80004000", inst, inst_fault, inst_pc);
        end
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        r0 = req_count;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_5000;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
                failures++;
                $display("FAIL err_halted[%0d]: got rv=%b iv=%b exp 0/0", i, imem_req_valid, inst_valid);
            end
        end
        redirect_valid = 1'b0;
        checks++;
        if (imem_req_addr !== 64'h8000_4004 || req_count !== r0) begin
            failures++;
            $display("FAIL err_pc: got a=%h reqs=%0d exp 80004004/%0d", imem_req_addr, req_count, r0);
        end
    endtask

    task automatic test_halt();
        int r0;
        int n;
        assert_reset();
        rst_n = 1'b1;
        tick();
        rsp_delay = 1;
        wait_inst(6, n);
        checks++;
        if (inst !== 32'h0000_0013 || inst_pc !== 64'h8000_0000 || inst_fault !== 1'b0) begin
            failures++;
            $display("FAIL halt_inst: got i=%h pc=%h f=%b exp 00000013/80000000/0", inst, inst_pc, inst_fault);
        end
        halt       = 1'b1;
        inst_ready = 1'b1;
        tick();
        halt       = 1'b0;
        inst_ready = 1'b0;
        r0 = req_count;
        checks++;
        if (imem_req_addr !== 64'h8000_0004 || imem_req_valid !== 1'b0) begin
            failures++;
            $display("FAIL halt_pc: got a=%h rv=%b exp 80000004/0", imem_req_addr, imem_req_valid);
        end
        repeat (4) tick();
        checks++;
        if (req_count !== r0 || inst_valid !== 1'b0) begin
            failures++;
            $display("FAIL halt_quiet: got reqs=%0d iv=%b exp %0d/0", req_count, inst_valid, r0);
        end
        assert_reset();
        rst_n = 1'b1;
        tick();
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0000) begin
            failures++;
            $display("FAIL halt_restart: got rv=%b a=%h exp 1/80000000", imem_req_valid, imem_req_addr);
        end
        halt = 1'b1;
        #1;
        checks++;
        if (imem_req_valid !== 1'b0) begin
            failures++;
            $display("FAIL halt_req_mask: got rv=%b exp 0", imem_req_valid);
        end
        tick();
        halt = 1'b0;
        tick();
        checks++;
        if (imem_req_valid !== 1'b0 || req_count !== r0) begin
            failures++;
            $display("FAIL halt_in_req: got rv=%b reqs=%0d exp 0/%0d", imem_req_valid, req_count, r0);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_zero_wait();
        test_stall();
        test_redirect_wait();
        test_back_to_back_redirect();
        test_redirect_out();
        test_error();
        test_halt();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ysyx_22050612_ifu.md
# ysyx_22050612_ifu

Instruction fetch unit for the single-issue RV64 core. Holds the program counter, issues one 32-bit instruction fetch at a time to instruction memory over a request/response handshake, and presents the fetched word with its PC to the decode stage over a valid/ready handshake. Control transfers are taken via a redirect port from execute, which squashes any in-flight fetch. Halt and memory error stop further fetching.

## Interface
Parameters:
- RESET_PC, 64'h0000_0000_8000_0000, PC loaded on reset
- XLEN, 64, PC/address width

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- redirect_valid  in  1  take control transfer this cycle
- redirect_pc  in  XLEN  redirect target; bits [1:0] ignored (forced 0)
- halt  in  1  stop fetching (ebreak retired); sticky inside block
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  XLEN  fetch address (= pc)
- imem_rsp_valid  in  1  response valid (one per accepted request, ≥1 cycle later)
- imem_rsp_data  in  32  instruction word
- imem_rsp_err  in  1  access fault on this response
- inst_valid  out  1  instruction available to decode
- inst_ready  in  1  decode accepts instruction
- inst  out  32  instruction word
- inst_pc  out  XLEN  PC of inst
- inst_fault  out  1  inst came from a faulting fetch

## Operation
- States: IDLE, REQ, WAIT, OUT, HALT. Reset → IDLE; IDLE → REQ unconditionally next cycle.
- REQ: imem_req_valid=1, addr=pc. On req_ready → WAIT. If halt=1, imem_req_valid forced 0 that cycle, → HALT.
- WAIT: on imem_rsp_valid with drop=0 → capture data/err into inst/inst_fault, inst_pc←pc, → OUT. With drop=1 → discard, clear drop, → REQ.
- OUT: inst_valid=1; inst/inst_pc/inst_fault stable. On inst_ready: pc←pc+4 (mod 2^64); if inst_fault → HALT, else if halt → HALT, else → REQ.
- HALT: no outputs asserted; exit only by reset; redirect ignored.
- Redirect (any of REQ/WAIT/OUT, highest priority over all other transitions except reset):
  - pc←{redirect_pc[63:2],2'b00}.
  - REQ with req_ready same cycle: request fires with old pc; → WAIT, drop←1.
  - REQ without req_ready: stay REQ (next request uses new pc).
  - WAIT, no rsp this cycle: drop←1, stay WAIT. WAIT with rsp same cycle: discard rsp, → REQ.
  - OUT: output cancelled, → REQ; a same-cycle inst_ready handshake is not counted (no pc+4); decode ignores it.
  - Back-to-back redirects: last one wins; drop stays 1.
- Error response: inst←32'h0000_0013 (nop), inst_fault=1.
- Exactly one outstanding request at any time.

## Timing
- Reset values: state IDLE, pc=RESET_PC, drop=0, inst=0, inst_pc=0, inst_fault=0, imem_req_valid=0, inst_valid=0, imem_req_addr=RESET_PC.
- First imem_req_valid one cycle after rst_n deasserts.
- Zero-wait memory (ready=1, rsp next cycle): inst_valid 2 cycles after request cycle; sustained throughput 1 inst / 3 cycles with inst_ready=1.
- All outputs registered or decoded from state only; no combinational path input→output except halt→imem_req_valid.
- Async reset mid-WAIT: in-flight response after reset is ignored (state IDLE/REQ does not sample rsp).

## Structure
- Shared package ysyx_22050612_pkg: state enum, RESET_PC default, NOP_INST=32'h0000_0013, EBREAK_INST=32'h0010_0073.
- No sub-module; single FSM plus pc/drop/output registers.

## Test plan
- Reset, zero-wait memory returning 0x00000013, 0x00100093, inst_ready=1 → inst_pc 0x80000000 then 0x80000004, inst values match, one req per inst.
- Memory req_ready stalled 3 cycles, rsp delayed 4 → imem_req_addr stable during stall; single inst delivered; inst_ready low 5 cycles holds inst/inst_pc stable.
- Redirect to 0x80001002 while in WAIT, stale rsp arrives next cycle → stale word not delivered; next req addr 0x80001000.
- Redirect in REQ coincident with req_ready, then redirect again in WAIT → one response dropped, fetch resumes at second target.
- imem_rsp_err=1 → inst=0x00000013, inst_fault=1; after acceptance no further imem_req_valid.
- halt asserted in OUT → after acceptance pc advanced by 4, no further requests; rst_n low then high → fetch restarts at 0x80000000.
